// File: rtl/or1200_vld_top.sv
// JPEG entropy bit reader for the OR1200 custom-instruction datapath.
// Fetches bytes from memory one at a time and removes stuffed 0x00 bytes
// that follow 0xFF. Bits are kept MSB-aligned in a bit buffer, and the reader
// serves 1..16-bit get-bits requests. The CPU is stalled until enough bits are
// buffered. A marker (0xFF followed by a non-zero byte) halts fetching. Once
// halted, short requests are padded with 1s.

module or1200_vld_top #(
    parameter int BUF_W    = 32,
    parameter int MAX_BITS = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        spr_cs,
    input  logic        spr_write,
    input  logic [1:0]  spr_addr,
    input  logic [31:0] spr_dat_i,
    output logic [31:0] spr_dat_o,
    input  logic        get_bit_op_i,
    input  logic [4:0]  num_bits_i,
    output logic [31:0] dat_o,
    output logic        stall_cpu_o,
    output logic        rd_req_o,
    output logic [31:0] vld_addr_o,
    input  logic        ack_i,
    input  logic [7:0]  rd_dat_i
);

    typedef enum logic {F_IDLE, F_REQ} fetch_state_t;

    localparam logic [5:0] FETCH_MAX = 6'(BUF_W - 8);

    fetch_state_t      state;
    logic [BUF_W-1:0]  bit_buf;
    logic [5:0]        fill;
    logic              ff_seen;
    logic              halted;
    logic [31:0]       addr;

    logic              addr_wr;
    logic              short_req;
    logic              consume;
    logic              pad_fill;
    logic              spr_addr_unused;
    logic [5:0]        n_ext;
    logic [5:0]        fill_c;
    logic [BUF_W-1:0]  buf_c;
    logic [BUF_W-1:0]  buf_ins;
    logic [BUF_W-1:0]  buf_pad;
    logic [MAX_BITS-1:0] extracted;

    assign addr_wr         = spr_cs & spr_write & spr_addr[1];
    assign spr_addr_unused = spr_addr[0];
    assign n_ext           = {1'b0, num_bits_i};
    assign short_req       = n_ext > fill;
    // An address write in the same cycle flushes the buffer. So the op must
    // not complete against the old contents; it stalls and retries on the
    // new stream.
    assign stall_cpu_o     = get_bit_op_i & ((short_req & ~halted) | addr_wr);
    assign consume         = get_bit_op_i & ~stall_cpu_o;
    assign pad_fill        = halted & short_req;
    assign rd_req_o        = (state == F_REQ);
    assign vld_addr_o      = addr;
    assign dat_o           = consume ? {{(32-MAX_BITS){1'b0}}, extracted} : 32'd0;

    // Extract the top n bits right-justified, with 1-padding below the valid bits once halted
    always_comb begin
        buf_pad = bit_buf;
        if (pad_fill) begin
            buf_pad = bit_buf | ({BUF_W{1'b1}} >> fill);
        end
        extracted = MAX_BITS'(buf_pad >> (7'(BUF_W) - {2'b00, num_bits_i}));
    end

    // Post-consume buffer view, and the position of an incoming byte behind the remaining bits
    always_comb begin
        buf_c  = bit_buf;
        fill_c = fill;
        if (consume) begin
            if (pad_fill) begin
                buf_c  = '0;
                fill_c = '0;
            end else begin
                buf_c  = bit_buf << num_bits_i;
                fill_c = fill - n_ext;
            end
        end
        buf_ins = {{(BUF_W-8){1'b0}}, rd_dat_i} << (FETCH_MAX - fill_c);
    end

    // Buffer, unstuffing state and byte fetch FSM; address writes flush and restart the stream
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= F_IDLE;
            bit_buf <= '0;
            fill    <= '0;
            ff_seen <= 1'b0;
            halted  <= 1'b0;
            addr    <= '0;
        end else if (addr_wr) begin
            state   <= F_IDLE;
            bit_buf <= '0;
            fill    <= '0;
            ff_seen <= 1'b0;
            halted  <= 1'b0;
            addr    <= spr_dat_i;
        end else begin
            bit_buf <= buf_c;
            fill    <= fill_c;
            case (state)
                F_IDLE: begin
                    if (fill <= FETCH_MAX && !halted) begin
                        state <= F_REQ;
                    end
                end
                F_REQ: begin
                    if (halted) begin
                        state <= F_IDLE;
                    end else if (ack_i) begin
                        state <= F_IDLE;
                        addr  <= addr + 32'd1;
                        if (ff_seen) begin
                            ff_seen <= 1'b0;
                            if (rd_dat_i != 8'h00) begin
                                halted <= 1'b1;
                            end
                        end else begin
                            bit_buf <= buf_c | buf_ins;
                            fill    <= fill_c + 6'd8;
                            if (rd_dat_i == 8'hFF) begin
                                ff_seen <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= F_IDLE;
            endcase
        end
    end

    // SPR read mux: fetch address, or status {halted, ff_seen, fill}
    always_comb begin
        spr_dat_o = 32'd0;
        if (spr_cs) begin
            spr_dat_o = spr_addr[1] ? addr : {24'd0, halted, ff_seen, fill};
        end
    end

endmodule
